uart_irq_arbiter: RTL

- Parametrised successor of the UART interrupt controller.
- Takes NUM_SRC interrupt sources. Each source is configurable as level- or edge-sensitive and can be enabled at run time.
- Holds edge events in sticky pending bits until the CPU acknowledges them, then resolves a fixed-priority interrupt ID.
- An optional post-acknowledge holdoff window suppresses irq re-assertion. Sits between the UART datapath status flags and the host bus/IIR register logic.

---
 rtl/uart_irq_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_irq_arbiter.sv
// uart_irq_arbiter: sticky/level interrupt collector with a fixed-priority ID
// encoder, host acknowledge handling and an optional post-ack holdoff window.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   src_raw     - raw interrupt conditions from the UART datapath
//   src_en      - per-source run-time enable (IER)
//   ack, ack_id - single-cycle host acknowledge and the ID being acknowledged
//   irq         - registered interrupt request
//   irq_id      - registered highest-priority pending index, all-ones when idle
//   pending     - registered pending vector for status readback
//   ack_err     - one-cycle pulse when an ack is rejected
module uart_irq_arbiter #(
  parameter int unsigned       NUM_SRC   = 6,
  parameter int unsigned       ID_W      = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 6'b000100,
  parameter int unsigned       HOLDOFF   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_raw,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               ack,
  input  logic [ID_W-1:0]    ack_id,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               ack_err
);

  localparam int unsigned CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [ID_W-1:0] ID_NONE = {ID_W{1'b1}};

  logic [NUM_SRC-1:0] raw_q;
  logic [CNT_W-1:0]   hold_cnt;

  logic               ack_acc;
  logic               ack_rej;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [CNT_W-1:0]   hold_cnt_nxt;

  // Ack is judged against the registered irq_id visible to the host this cycle
  always_comb begin
    ack_acc = ack && (irq_id != ID_NONE) && (ack_id == irq_id);
    ack_rej = ack && !ack_acc;
  end

  // Next pending vector: level sources follow the input, edge sources are sticky
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (EDGE_MASK[i]) begin
        if (!src_en[i]) begin
          pending_nxt[i] = 1'b0;
        end else if (src_raw[i] && !raw_q[i]) begin
          pending_nxt[i] = 1'b1;  // a new edge wins over a same-cycle clear
        end else if (ack_acc && (ack_id == ID_W'(i))) begin
          pending_nxt[i] = 1'b0;
        end
      end else begin
        pending_nxt[i] = src_raw[i] & src_en[i];
      end
    end
  end

  // Fixed priority: lowest set index wins
  always_comb begin
    id_nxt = ID_NONE;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        id_nxt = ID_W'(i);
      end
    end
  end

  // Holdoff counter: (re)load on accepted ack, otherwise count down to zero
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (ack_acc && (HOLDOFF > 0)) begin
      hold_cnt_nxt = CNT_W'(HOLDOFF);
    end else if (hold_cnt != '0) begin
      hold_cnt_nxt = hold_cnt - CNT_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= '0;
      pending  <= '0;
      irq_id   <= ID_NONE;
      irq      <= 1'b0;
      ack_err  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      raw_q    <= src_raw;
      pending  <= pending_nxt;
      irq_id   <= id_nxt;
      irq      <= (pending != '0) && (hold_cnt_nxt == '0);
      ack_err  <= ack_rej;
      hold_cnt <= hold_cnt_nxt;
    end
  end

endmodule
